// File: rtl/uart_cmd_responder.sv
// Serial register-access responder: parses A5/CMD/ADDR[/DATA] frames from the UART RX FIFO,
// performs one register bus read or write, and returns a 5A/STATUS/VALUE frame to the TX FIFO.
module uart_cmd_responder #(
    parameter int REG_COUNT   = 16,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_byte,
    output logic       rx_pop,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] SYNC_REQ    = 8'hA5;
    localparam logic [7:0] SYNC_RESP   = 8'h5A;
    localparam logic [7:0] CMD_WR      = 8'h01;
    localparam logic [7:0] CMD_RD      = 8'h02;
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CMD  = 8'hE1;
    localparam logic [7:0] ST_BAD_ADDR = 8'hE2;
    localparam logic [8:0] REG_LIMIT   = 9'(REG_COUNT);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP0,
        ST_RESP1,
        ST_RESP2
    } state_t;

    state_t           state, state_d;
    logic             is_wr, is_wr_d;
    logic [7:0]       reg_addr_d, reg_wdata_d;
    logic [7:0]       status, status_d;
    logic [7:0]       value, value_d;
    logic [7:0]       err_cnt_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    logic             in_frame, tmo_hit, new_addr_ok, held_addr_ok;

    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        in_frame     = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
        tmo_hit      = in_frame && (tmo_cnt == TMO_LIMIT);
        new_addr_ok  = {1'b0, rx_byte}  < REG_LIMIT;
        held_addr_ok = {1'b0, reg_addr} < REG_LIMIT;

        state_d     = state;
        is_wr_d     = is_wr;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        status_d    = status;
        value_d     = value;
        err_cnt_d   = err_cnt;
        tmo_cnt_d   = (in_frame && rx_empty) ? tmo_cnt + 1'b1 : '0;
        rx_pop      = 1'b0;
        tx_push     = 1'b0;
        tx_byte     = 8'h00;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;

        if (tmo_hit) begin
            // Host went quiet mid-frame: drop it silently and count the abort.
            state_d   = ST_IDLE;
            tmo_cnt_d = '0;
            if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        rx_pop = 1'b1;
                        if (rx_byte == SYNC_REQ) state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!rx_empty) begin
                        rx_pop  = 1'b1;
                        is_wr_d = (rx_byte == CMD_WR);
                        if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
                            state_d = ST_ADDR;
                        end else begin
                            status_d = ST_BAD_CMD;
                            value_d  = 8'h00;
                            state_d  = ST_RESP0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!rx_empty) begin
                        rx_pop     = 1'b1;
                        reg_addr_d = rx_byte;
                        if (is_wr) begin
                            state_d = ST_DATA;
                        end else if (new_addr_ok) begin
                            state_d = ST_EXEC;
                        end else begin
                            status_d = ST_BAD_ADDR;
                            value_d  = 8'h00;
                            state_d  = ST_RESP0;
                        end
                    end
                end
                ST_DATA: begin
                    // The data byte is consumed even for a bad address so the stream stays framed.
                    if (!rx_empty) begin
                        rx_pop      = 1'b1;
                        reg_wdata_d = rx_byte;
                        if (held_addr_ok) begin
                            state_d = ST_EXEC;
                        end else begin
                            status_d = ST_BAD_ADDR;
                            value_d  = 8'h00;
                            state_d  = ST_RESP0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (is_wr) begin
                        reg_wr   = 1'b1;
                        status_d = ST_OK;
                        value_d  = reg_wdata;
                        state_d  = ST_RESP0;
                    end else begin
                        reg_rd  = 1'b1;
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    status_d = ST_OK;
                    value_d  = reg_rdata;
                    state_d  = ST_RESP0;
                end
                ST_RESP0: begin
                    tx_byte = SYNC_RESP;
                    if (!tx_full) begin
                        tx_push = 1'b1;
                        state_d = ST_RESP1;
                    end
                end
                ST_RESP1: begin
                    tx_byte = status;
                    if (!tx_full) begin
                        tx_push = 1'b1;
                        state_d = ST_RESP2;
                    end
                end
                ST_RESP2: begin
                    tx_byte = value;
                    if (!tx_full) begin
                        tx_push = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Strobes are combinational from state, so mask them while reset is being
        // sampled; otherwise a FIFO could be popped or pushed by a frame being dropped.
        if (rst) begin
            rx_pop  = 1'b0;
            tx_push = 1'b0;
            tx_byte = 8'h00;
            reg_wr  = 1'b0;
            reg_rd  = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_wr     <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            status    <= 8'h00;
            value     <= 8'h00;
            err_cnt   <= 8'h00;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_d;
            is_wr     <= is_wr_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            status    <= status_d;
            value     <= value_d;
            err_cnt   <= err_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
        end
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Register-access responder on the CPU side of the FIFO-buffered UART. It pops framed command bytes from the UART RX FIFO port and executes single-byte register reads and writes on a local register bus. It then pushes a 3-byte response frame into the UART TX FIFO port. This lets a host PC read and write fabric registers over the serial link without a soft processor.

## Interface
- REG_COUNT, 16: number of valid register addresses (0..REG_COUNT-1), 1..256
- TIMEOUT_CYC, 200000: maximum idle cycles between bytes inside a frame (1 ms at 200 MHz)
- sys_clk  in  1  system clock; everything on its rising edge
- rst  in  1  synchronous, active-high reset
- rx_empty  in  1  RX FIFO empty flag
- rx_byte  in  8  RX FIFO head byte; first-word-fall-through, valid whenever rx_empty=0
- rx_pop  out  1  one-cycle pop strobe; asserted only when rx_empty=0
- tx_full  in  1  TX FIFO full flag
- tx_push  out  1  one-cycle write strobe; asserted only when tx_full=0
- tx_byte  out  8  byte written with tx_push
- reg_addr  out  8  register bus address
- reg_wdata  out  8  register bus write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_rd
- busy  out  1  high in every state except IDLE
- err_cnt  out  8  count of aborted frames, saturates at 255

## Operation
- Request frame: 0xA5 sync, CMD, ADDR, then DATA only if CMD=0x01.
  - CMD 0x01 is write; CMD 0x02 is read.
- Response frame: 0x5A, STATUS, VALUE.
  - STATUS 0x00 ok.
  - STATUS 0xE1 bad command; VALUE 0x00.
  - STATUS 0xE2 address >= REG_COUNT; VALUE 0x00.
  - On ok write, VALUE is the data echoed back. On ok read, VALUE is the reg_rdata captured.
- States: IDLE, CMD, ADDR, DATA, EXEC, RD_WAIT, RESP0, RESP1, RESP2.
- IDLE: pops every available byte.
  - 0xA5 → CMD.
  - Any other byte is discarded silently, with no error count.
- CMD: pops the byte and latches it.
  - 0x01 or 0x02 → ADDR.
  - Anything else → RESP0 with status 0xE1; no further bytes are consumed.
- ADDR: pops and latches reg_addr.
  - Write → DATA.
  - Read, valid address → EXEC.
  - Read, invalid address → RESP0 with 0xE2.
- DATA: pops and latches reg_wdata.
  - Valid address → EXEC.
  - Invalid address → RESP0 with 0xE2. The data byte is still consumed to keep framing.
- EXEC: asserts reg_wr or reg_rd for exactly one cycle.
  - Write → RESP0.
  - Read → RD_WAIT.
- RD_WAIT: captures reg_rdata → RESP0.
- RESP0/1/2: each pushes one response byte when tx_full=0, otherwise holds with tx_push=0. RESP2 → IDLE after its push.
- Timeout: one counter, cleared on each pop.
  - It increments while in CMD, ADDR or DATA with rx_empty=1.
  - On reaching TIMEOUT_CYC: → IDLE, err_cnt +1 (saturating), no response, no bus access.
- RX bytes are never popped outside IDLE/CMD/ADDR/DATA. Bytes arriving during EXEC..RESP2 stay in the FIFO.
- reg_addr and reg_wdata hold their last latched values between frames.

## Timing
- Reset values:
  - Strobes: rx_pop, tx_push, reg_wr, reg_rd = 0.
  - Buses: tx_byte, reg_addr, reg_wdata = 0x00.
  - Status: busy = 0, err_cnt = 0.
  - State is IDLE and the timeout counter is 0.
- Reset mid-frame or mid-response: partial frame and pending response are dropped. Strobes are low in the cycle after rst is sampled.
- Pop: rx_pop is combinational from state and rx_empty. rx_byte is sampled in the same cycle. Back-to-back pops in consecutive cycles are allowed.
- Write, last byte popped in cycle N: reg_wr at N+1; 0x5A pushed at N+2 at the earliest.
- Read, ADDR popped in cycle N: reg_rd at N+1; reg_rdata sampled at N+2; 0x5A pushed at N+3 at the earliest.
- Response: with tx_full=0 throughout, the three pushes occur in 3 consecutive cycles. IDLE may pop again in the cycle after the RESP2 push.
- tx_full rising mid-response: hold the current byte and resume with no loss and no duplication.
- Timeout fires in the cycle the counter equals TIMEOUT_CYC; the counter is then cleared.

## Test plan
- Write: push A5 01 03 7E → one reg_wr with addr 0x03, data 0x7E; TX receives 5A 00 7E; err_cnt stays 0.
- Read: push A5 02 05, model returns 0xC3 one cycle after reg_rd → TX receives 5A 00 C3; reg_rd pulses once, reg_wr never.
- Errors: A5 09 → 5A E1 00 with no bus strobe. A5 02 10 with REG_COUNT=16 → 5A E2 00. A5 01 20 55 → 5A E2 00, data byte consumed, no reg_wr.
- Garbage and back-pressure: 00 FF A5 02 01 with tx_full held high for 10 cycles mid-response → garbage discarded; exactly 5A 00 xx delivered in order once tx_full drops.
- Timeout: TIMEOUT_CYC=50, push A5 01 then stall 60 cycles → return to IDLE at gap cycle 50, err_cnt=1, no TX bytes. A following valid frame is served normally.
- Reset: assert rst during RESP1 → no further tx_push, all outputs at reset values. The next frame after deassertion is handled correctly.
